// File: rtl/arb_defs.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// an elaboration-time clog2 helper.
package arb_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    // Ceiling log2, usable in localparam expressions; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Circular priority encoder: finds the first set bit of v searching
// p, p+1, ..., N-1, 0, ..., p-1. Rotates v so that bit p lands at index 0,
// does a low-index-first encode, then maps the winner back.
module rr_prio_enc #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   v,
    input  logic [IDW-1:0] p,
    output logic           found,
    output logic [IDW-1:0] idx
);

    logic [N-1:0] rot;
    int           pos;
    int           sum;

    // Rotate right by p so the search start becomes bit 0 (explicit wrap for non-power-of-2 N).
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            int j;
            j = i + int'(p);
            if (j >= N) begin
                j = j - N;
            end
            rot[i] = v[j];
        end
    end

    // Lowest set bit of the rotated vector wins; undo the rotation on its index.
    always_comb begin
        found = 1'b0;
        pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                pos   = i;
            end
        end
        sum = pos + int'(p);
        if (sum >= N) begin
            sum = sum - N;
        end
        idx = IDW'(sum);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold, hold-limit preemption and enable.
// The owner keeps the grant until it drops its request, MAX_HOLD cycles
// elapse, or en drops; on release the next requester after the owner is
// granted on the same edge.
module rr_arbiter
    import arb_defs::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [N-1:0]          req,
    output logic [N-1:0]          gnt,
    output logic [clog2(N)-1:0]   gnt_id,
    output logic                  gnt_vld,
    output logic                  preempt
);

    localparam int IDW = clog2(N);
    localparam int HCW = clog2(MAX_HOLD + 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic           preempt_q, preempt_d;

    logic [IDW-1:0] owner_inc;
    logic [IDW-1:0] enc_p;
    logic           enc_found;
    logic [IDW-1:0] enc_idx;
    logic           release_now;
    logic           timeout;

    // Successor of the owner with an explicit wrap, and the search start for the encoder.
    always_comb begin
        owner_inc = (owner_q == IDW'(N - 1)) ? '0 : owner_q + 1'b1;
        enc_p     = (state_q == ST_IDLE) ? ptr_q : owner_inc;
    end

    rr_prio_enc #(
        .N   (N),
        .IDW (IDW)
    ) u_enc (
        .v     (req),
        .p     (enc_p),
        .found (enc_found),
        .idx   (enc_idx)
    );

    // Next-state logic: idle arbitration, en drop, release/hand-over, hold counting.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        preempt_d   = 1'b0;
        timeout     = (hold_q == HCW'(MAX_HOLD - 1));
        release_now = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && enc_found) begin
                    state_d = ST_GRANT;
                    owner_d = enc_idx;
                    hold_d  = '0;
                end
            end
            ST_GRANT: begin
                release_now = !req[owner_q] || timeout;
                if (!en) begin
                    state_d = ST_IDLE;
                    ptr_d   = owner_inc;
                    hold_d  = '0;
                end else if (release_now) begin
                    ptr_d = owner_inc;
                    if (enc_found) begin
                        owner_d   = enc_idx;
                        hold_d    = '0;
                        // Only a forced hand-over to someone else counts as preemption.
                        preempt_d = req[owner_q] && timeout && (enc_idx != owner_q);
                    end else begin
                        state_d = ST_IDLE;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    // State, owner, pointer, hold counter and preempt pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    // Grant outputs decoded straight from the state/owner flops.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        if (state_q == ST_GRANT) begin
            gnt[owner_q] = 1'b1;
            gnt_id       = owner_q;
            gnt_vld      = 1'b1;
        end
        preempt = preempt_q;
    end

endmodule
